// File: rtl/cdb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | cdb_arbiter: three one-entry result latches (alu/lsb/bru) arbitrated   |
// | onto the common data bus. Round-robin unless CDB_ARB_FIXED_PRIO_EN.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module cdb_arbiter #(
   parameter int ROB_ID_W = 4,
   parameter int DATA_W   = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   input  logic                clear,
   input  logic                alu_valid,
   input  logic [ROB_ID_W-1:0] alu_rob_id,
   input  logic [DATA_W-1:0]   alu_val,
   input  logic                lsb_valid,
   input  logic [ROB_ID_W-1:0] lsb_rob_id,
   input  logic [DATA_W-1:0]   lsb_val,
   input  logic                bru_valid,
   input  logic [ROB_ID_W-1:0] bru_rob_id,
   input  logic [DATA_W-1:0]   bru_val,
   output logic                alu_ready,
   output logic                lsb_ready,
   output logic                bru_ready,
   output logic                cdb_valid,
   output logic [ROB_ID_W-1:0] cdb_rob_id,
   output logic [DATA_W-1:0]   cdb_val
);

   localparam int C_NREQ = 3;

   logic [C_NREQ-1:0]   w_valid;
   logic [C_NREQ-1:0]   w_grant;
   logic [C_NREQ-1:0]   w_ready;
   logic [C_NREQ-1:0]   w_xfer;
   logic [1:0]          w_gidx;
   logic                w_any;
   logic [ROB_ID_W-1:0] w_in_id  [C_NREQ];
   logic [DATA_W-1:0]   w_in_val [C_NREQ];

   logic [C_NREQ-1:0]   r_occ;
   logic [ROB_ID_W-1:0] r_lat_id  [C_NREQ];
   logic [DATA_W-1:0]   r_lat_val [C_NREQ];
   logic                r_cdb_valid;
   logic [ROB_ID_W-1:0] r_cdb_rob_id;
   logic [DATA_W-1:0]   r_cdb_val;

   assign w_valid     = {bru_valid, lsb_valid, alu_valid};
   assign w_in_id[0]  = alu_rob_id;
   assign w_in_id[1]  = lsb_rob_id;
   assign w_in_id[2]  = bru_rob_id;
   assign w_in_val[0] = alu_val;
   assign w_in_val[1] = lsb_val;
   assign w_in_val[2] = bru_val;

`ifdef CDB_ARB_FIXED_PRIO_EN
   always_comb begin
      w_grant = '0;
      w_gidx  = 2'd0;
      w_any   = 1'b0;
      for (int i = 0; i < C_NREQ; i++) begin
         if (r_occ[i] && !w_any) begin
            w_grant[i] = 1'b1;
            w_gidx     = 2'(i);
            w_any      = 1'b1;
         end
      end
   end
`else
   logic [1:0] r_ptr;
   logic [2:0] w_sum;
   logic [1:0] w_idx;

   // Search from the pointer, wrapping modulo 3.
   always_comb begin
      w_grant = '0;
      w_gidx  = 2'd0;
      w_any   = 1'b0;
      w_sum   = 3'd0;
      w_idx   = 2'd0;
      for (int i = 0; i < C_NREQ; i++) begin
         w_sum = {1'b0, r_ptr} + 3'(i);
         w_idx = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
         if (r_occ[w_idx] && !w_any) begin
            w_grant[w_idx] = 1'b1;
            w_gidx         = w_idx;
            w_any          = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_ptr <= 2'd0;
      else if (!clear && rdy && w_any)
         r_ptr <= (w_gidx == 2'd2) ? 2'd0 : w_gidx + 2'd1;
   end
`endif

   // A granted latch drains this edge, so it may refill at the same time.
   assign w_ready = {C_NREQ{rdy & ~clear}} & (~r_occ | w_grant);
   assign w_xfer  = w_valid & w_ready;

   generate
      for (genvar k = 0; k < C_NREQ; k++) begin : g_lat
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_lat_id[k]  <= '0;
               r_lat_val[k] <= '0;
            end else if (w_xfer[k]) begin
               r_lat_id[k]  <= w_in_id[k];
               r_lat_val[k] <= w_in_val[k];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_occ        <= '0;
         r_cdb_valid  <= 1'b0;
         r_cdb_rob_id <= '0;
         r_cdb_val    <= '0;
      end else if (clear) begin
         r_occ        <= '0;
         r_cdb_valid  <= 1'b0;
      end else if (rdy) begin
         r_occ        <= w_xfer | (r_occ & ~w_grant);
         r_cdb_valid  <= w_any;
         if (w_any) begin
            r_cdb_rob_id <= r_lat_id[w_gidx];
            r_cdb_val    <= r_lat_val[w_gidx];
         end
      end
   end

   assign alu_ready  = w_ready[0];
   assign lsb_ready  = w_ready[1];
   assign bru_ready  = w_ready[2];
   assign cdb_valid  = r_cdb_valid;
   assign cdb_rob_id = r_cdb_rob_id;
   assign cdb_val    = r_cdb_val;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_cdb_arbiter: directed and random checks of cdb_arbiter against a    |
// | per-requester slot reference model. Revision: 1.0                      |
// +------------------------------------------------------------------------+
module tb_cdb_arbiter;
   localparam int ROB_ID_W = 4;
   localparam int DATA_W   = 32;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                rdy = 1'b1;
   logic                clear = 1'b0;
   logic                v   [3];
   logic [ROB_ID_W-1:0] id  [3];
   logic [DATA_W-1:0]   val [3];
   logic                alu_ready, lsb_ready, bru_ready;
   logic                cdb_valid;
   logic [ROB_ID_W-1:0] cdb_rob_id;
   logic [DATA_W-1:0]   cdb_val;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   // reference model state
   bit                  m_occ [3];
   logic [ROB_ID_W-1:0] m_id  [3];
   logic [DATA_W-1:0]   m_val [3];
   int                  m_ptr;
   bit                  m_cv;
   logic [ROB_ID_W-1:0] m_cid;
   logic [DATA_W-1:0]   m_cval;

   cdb_arbiter #(.ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
      .alu_valid(v[0]), .alu_rob_id(id[0]), .alu_val(val[0]),
      .lsb_valid(v[1]), .lsb_rob_id(id[1]), .lsb_val(val[1]),
      .bru_valid(v[2]), .bru_rob_id(id[2]), .bru_val(val[2]),
      .alu_ready(alu_ready), .lsb_ready(lsb_ready), .bru_ready(bru_ready),
      .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int m_grant();
      for (int i = 0; i < 3; i++) begin
         int k;
         k = (m_ptr + i) % 3;
         if (m_occ[k]) return k;
      end
      return -1;
   endfunction

   function automatic logic [2:0] m_ready();
      logic [2:0] r;
      int g;
      g = m_grant();
      for (int k = 0; k < 3; k++)
         r[k] = rdy && !clear && (!m_occ[k] || g == k);
      return r;
   endfunction

   task automatic m_reset();
      for (int k = 0; k < 3; k++) m_occ[k] = 0;
      m_ptr  = 0;
      m_cv   = 0;
      m_cid  = '0;
      m_cval = '0;
   endtask

   task automatic check_cdb(input string tag);
      check({tag, ".cdb_valid"}, 64'(cdb_valid), 64'(m_cv));
      check({tag, ".cdb_rob_id"}, 64'(cdb_rob_id), 64'(m_cid));
      check({tag, ".cdb_val"}, 64'(cdb_val), 64'(m_cval));
   endtask

   // One clock: check ready before the edge, advance model, check bus after.
   task automatic tick(input string tag);
      logic [2:0] rd;
      logic [2:0] xf;
      int g;
      #1;
      rd = m_ready();
      check({tag, ".ready"}, 64'({bru_ready, lsb_ready, alu_ready}), 64'(rd));
      g = m_grant();
      for (int k = 0; k < 3; k++) xf[k] = v[k] & rd[k];
      @(posedge clk);
      #1;
      if (clear) begin
         for (int k = 0; k < 3; k++) m_occ[k] = 0;
         m_cv = 0;
      end else if (rdy) begin
         m_cv = (g >= 0);
         if (g >= 0) begin
            m_cid     = m_id[g];
            m_cval    = m_val[g];
            m_occ[g]  = 0;
            m_ptr     = (g + 1) % 3;
         end
         for (int k = 0; k < 3; k++)
            if (xf[k]) begin
               m_occ[k] = 1;
               m_id[k]  = id[k];
               m_val[k] = val[k];
            end
      end
      check_cdb(tag);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      m_reset();
      #1;
      check_cdb("reset");
      check("reset.ready", 64'({bru_ready, lsb_ready, alu_ready}), 64'({3{rdy & ~clear}}));
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic idle();
      for (int k = 0; k < 3; k++) v[k] = 1'b0;
   endtask

   task automatic offer(input int k, input logic [ROB_ID_W-1:0] i, input logic [DATA_W-1:0] d);
      v[k]   = 1'b1;
      id[k]  = i;
      val[k] = d;
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         v[k] = 1'b0; id[k] = '0; val[k] = '0;
      end
      m_reset();

      // reset values, with and without rdy
      rdy = 1'b0;
      #1;
      check("reset.ready_rdy0", 64'({bru_ready, lsb_ready, alu_ready}), 64'd0);
      rdy = 1'b1;
      do_reset();

      // single ALU result: visible after the second edge for one cycle only
      offer(0, 4'd3, 32'h1234);
      tick("single.e1");
      check("single.e1_novalid", 64'(cdb_valid), 64'd0);
      idle();
      tick("single.e2");
      check("single.e2_valid", 64'(cdb_valid), 64'd1);
      check("single.e2_id", 64'(cdb_rob_id), 64'd3);
      check("single.e2_val", 64'(cdb_val), 64'h1234);
      tick("single.e3");
      check("single.e3_drop", 64'(cdb_valid), 64'd0);

      // all three valid every cycle: alu, lsb, bru, alu ...
      do_reset();
      offer(0, 4'd1, 32'hA1);
      offer(1, 4'd2, 32'hB2);
      offer(2, 4'd3, 32'hC3);
      tick("rr.c1");
      for (int c = 0; c < 9; c++) begin
         tick("rr");
         check("rr.seq_id", 64'(cdb_rob_id), 64'((c % 3) + 1));
         check("rr.seq_valid", 64'(cdb_valid), 64'd1);
      end

      // clear discards pending lsb/bru results and leaves the pointer alone
      idle();
      do_reset();
      offer(0, 4'd1, 32'h11);
      tick("clr.alu_in");
      idle();
      tick("clr.alu_out");
      offer(1, 4'd5, 32'h55);
      offer(2, 4'd7, 32'h77);
      tick("clr.fill");
      idle();
      clear = 1'b1;
      tick("clr.pulse");
      clear = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick("clr.after");
         check("clr.no_bcast", 64'(cdb_valid), 64'd0);
         check("clr.id_held", 64'(cdb_rob_id), 64'd1);
      end
      offer(0, 4'd10, 32'hA0);
      offer(1, 4'd11, 32'hB0);
      offer(2, 4'd12, 32'hC0);
      tick("clr.refill");
      idle();
      tick("clr.first");
      check("clr.ptr_kept", 64'(cdb_rob_id), 64'd11);
      tick("clr.drain1");
      tick("clr.drain2");

      // rdy low freezes an ALU result, then it goes out on the next edge
      do_reset();
      offer(0, 4'd2, 32'h22);
      tick("rdy.in");
      idle();
      rdy = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick("rdy.hold");
         check("rdy.hold_ready", 64'({bru_ready, lsb_ready, alu_ready}), 64'd0);
         check("rdy.hold_valid", 64'(cdb_valid), 64'd0);
      end
      rdy = 1'b1;
      tick("rdy.out");
      check("rdy.out_id", 64'(cdb_rob_id), 64'd2);
      check("rdy.out_valid", 64'(cdb_valid), 64'd1);

      // asynchronous reset drops cdb_valid between edges
      rst = 1'b1;
      m_reset();
      #1;
      check("arst.valid", 64'(cdb_valid), 64'd0);
      check_cdb("arst");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // random traffic against the model
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 3; k++) begin
            v[k]   = ($urandom_range(0, 2) != 0);
            id[k]  = ROB_ID_W'($urandom);
            val[k] = $urandom;
         end
         rdy   = ($urandom_range(0, 7) != 0);
         clear = ($urandom_range(0, 19) == 0);
         tick("rand");
      end
      idle();
      rdy   = 1'b1;
      clear = 1'b0;
      for (int c = 0; c < 4; c++) tick("drain");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
